// File: rtl/cu_command_arbiter_pkg.sv
// Shared types for the CU command arbiter: channel indices, command line, buffer status,
// arbiter state and the round-robin pick helper.
package cu_command_arbiter_pkg;

  localparam int CMD_ARB_NUM_CHANNELS = 4;

  typedef enum logic [1:0] {
    CMD_CH_READ           = 2'd0,
    CMD_CH_PREFETCH_READ  = 2'd1,
    CMD_CH_PREFETCH_WRITE = 2'd2,
    CMD_CH_WRITE          = 2'd3
  } cmd_channel_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  command;
    logic [7:0]  tag;
    logic [63:0] address;
    logic [11:0] size;
  } CommandBufferLine;

  typedef struct packed {
    logic empty;
    logic alfull;
    logic full;
  } BufferStatus;

  typedef struct packed {
    cmd_channel_t rr_ptr;
    logic [7:0]   credit_count;
  } cmd_arb_state_t;

  // Offset of the first requester in a request vector already rotated to start at rr_ptr.
  function automatic logic [1:0] rr_pick(input logic [3:0] req_rot);
    casez (req_rot)
      4'b???1: rr_pick = 2'd0;
      4'b??10: rr_pick = 2'd1;
      4'b?100: rr_pick = 2'd2;
      4'b1000: rr_pick = 2'd3;
      default: rr_pick = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/cu_command_arbiter_fifo.sv
// cu_command_fifo: per-channel circular command buffer with registered
// empty/alfull/full status and a sticky overflow flag.
module cu_command_fifo
  import cu_command_arbiter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   rstn,
  input  logic                   push,
  input  CommandBufferLine       push_data,
  input  logic                   pop,
  output CommandBufferLine       head,
  output logic [$clog2(DEPTH):0] count,
  output BufferStatus            status,
  output logic                   overflow
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   ZERO_C    = {(AW+1){1'b0}};
  localparam logic [AW:0]   ONE_C     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ALFULL_C  = (AW+1)'(DEPTH - 2);
  localparam logic [AW-1:0] PTR_ONE_C = {{(AW-1){1'b0}}, 1'b1};

  CommandBufferLine mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic             push_ok_s;
  logic             pop_ok_s;
  BufferStatus      status_r;
  logic             overflow_r;

  // A pop frees the slot in the same cycle, so a full FIFO being popped still accepts a push.
  always_comb begin
    pop_ok_s  = pop && (count_r != ZERO_C);
    push_ok_s = push && ((count_r != DEPTH_C) || pop_ok_s);
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + ONE_C;
      2'b01:   count_nxt_s = count_r - ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy, status flags (from the next count) and sticky overflow.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= ZERO_C;
      status_r   <= '{empty: 1'b1, alfull: 1'b0, full: 1'b0};
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r         <= count_nxt_s;
      status_r.empty  <= (count_nxt_s == ZERO_C);
      status_r.alfull <= (count_nxt_s >= ALFULL_C);
      status_r.full   <= (count_nxt_s == DEPTH_C);
      overflow_r      <= overflow_r | (push && !push_ok_s);
    end
  end

  // Payload storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head     = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign status   = status_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/cu_command_arbiter.sv
// cu_command_arbiter: four command FIFOs, credit-gated round-robin onto one registered port.
// Optional per-channel grant statistics under CMD_ARB_STATS_EN.
module cu_command_arbiter
  import cu_command_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int CREDITS_INIT = 64,
  parameter int CREDITS_MAX  = 64
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             enabled_in,
  input  CommandBufferLine read_command_in,
  input  CommandBufferLine prefetch_read_command_in,
  input  CommandBufferLine prefetch_write_command_in,
  input  CommandBufferLine write_command_in,
  input  logic             credit_return_in,
  output BufferStatus      read_buffer_status,
  output BufferStatus      prefetch_read_buffer_status,
  output BufferStatus      prefetch_write_buffer_status,
  output BufferStatus      write_buffer_status,
  output CommandBufferLine command_out,
  output logic [7:0]       credit_count_out,
  output logic [3:0]       overflow_out
`ifdef CMD_ARB_STATS_EN
  ,
  output logic [0:127]     cmd_arb_stats_out
`endif
);

  localparam int         CW             = $clog2(FIFO_DEPTH);
  localparam logic [7:0] CREDITS_INIT_C = 8'(CREDITS_INIT);
  localparam logic [7:0] CREDITS_MAX_C  = 8'(CREDITS_MAX);

  CommandBufferLine cmd_in_s [CMD_ARB_NUM_CHANNELS];
  CommandBufferLine head_s   [CMD_ARB_NUM_CHANNELS];
  BufferStatus      status_s [CMD_ARB_NUM_CHANNELS];
  logic [CW:0]      count_s  [CMD_ARB_NUM_CHANNELS];
  logic [3:0]       pending_s;
  logic [3:0]       overflow_s;
  logic [3:0]       pop_s;
  logic [3:0]       req_rot_s;
  logic             grant_s;
  logic [1:0]       grant_ch_s;
  cmd_arb_state_t   state_r;
  CommandBufferLine cmd_r;

  assign cmd_in_s[CMD_CH_READ]           = read_command_in;
  assign cmd_in_s[CMD_CH_PREFETCH_READ]  = prefetch_read_command_in;
  assign cmd_in_s[CMD_CH_PREFETCH_WRITE] = prefetch_write_command_in;
  assign cmd_in_s[CMD_CH_WRITE]          = write_command_in;

  for (genvar ch = 0; ch < CMD_ARB_NUM_CHANNELS; ch++) begin : g_fifo
    cu_command_fifo #(
      .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
      .clock     (clock),
      .rstn      (rstn),
      .push      (cmd_in_s[ch].valid),
      .push_data (cmd_in_s[ch]),
      .pop       (pop_s[ch]),
      .head      (head_s[ch]),
      .count     (count_s[ch]),
      .status    (status_s[ch]),
      .overflow  (overflow_s[ch])
    );
    assign pending_s[ch] = (count_s[ch] != {(CW+1){1'b0}});
  end

  // Rotate requests so bit 0 is the channel at rr_ptr, then take the first one set.
  always_comb begin
    req_rot_s  = 4'({pending_s, pending_s} >> state_r.rr_ptr);
    grant_s    = 1'b0;
    grant_ch_s = state_r.rr_ptr;
    pop_s      = 4'b0000;
    if (enabled_in && (state_r.credit_count != 8'd0) && (req_rot_s != 4'b0000)) begin
      grant_s           = 1'b1;
      grant_ch_s        = state_r.rr_ptr + rr_pick(req_rot_s);
      pop_s[grant_ch_s] = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Round-robin pointer, saturating credit counter and the registered command port.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_r <= '{rr_ptr: CMD_CH_READ, credit_count: CREDITS_INIT_C};
      cmd_r   <= '{valid: 1'b0, command: 8'd0, tag: 8'd0, address: 64'd0, size: 12'd0};
    end else begin
      if (grant_s) begin
        state_r.rr_ptr <= cmd_channel_t'(grant_ch_s + 2'd1);
        cmd_r          <= head_s[grant_ch_s];
        cmd_r.valid    <= 1'b1;
      end else begin
        state_r.rr_ptr <= state_r.rr_ptr;
        cmd_r.valid    <= 1'b0;
      end
      case ({grant_s, credit_return_in})
        2'b10:   state_r.credit_count <= state_r.credit_count - 8'd1;
        2'b01:   state_r.credit_count <= (state_r.credit_count < CREDITS_MAX_C) ?
                                         state_r.credit_count + 8'd1 : state_r.credit_count;
        default: state_r.credit_count <= state_r.credit_count;
      endcase
    end
  end

  assign read_buffer_status           = status_s[CMD_CH_READ];
  assign prefetch_read_buffer_status  = status_s[CMD_CH_PREFETCH_READ];
  assign prefetch_write_buffer_status = status_s[CMD_CH_PREFETCH_WRITE];
  assign write_buffer_status          = status_s[CMD_CH_WRITE];
  assign command_out                  = cmd_r;
  assign credit_count_out             = state_r.credit_count;
  assign overflow_out                 = overflow_s;

`ifdef CMD_ARB_STATS_EN
  logic [31:0] grant_cnt_r [CMD_ARB_NUM_CHANNELS];

  // Free-running per-channel grant counters; they wrap.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CMD_ARB_NUM_CHANNELS; i++) begin
        grant_cnt_r[i] <= 32'd0;
      end
    end else begin
      if (grant_s) begin
        grant_cnt_r[grant_ch_s] <= grant_cnt_r[grant_ch_s] + 32'd1;
      end
    end
  end

  assign cmd_arb_stats_out = {grant_cnt_r[0], grant_cnt_r[1], grant_cnt_r[2], grant_cnt_r[3]};
`endif

endmodule

// File: tb/tb_cu_command_arbiter.sv
// Scoreboard bench for cu_command_arbiter: queue-based reference model plus a negedge monitor.
module tb_cu_command_arbiter;
  import cu_command_arbiter_pkg::*;

  localparam int DEPTH = 8;
  localparam int CINIT = 64;
  localparam int CMAX  = 64;

  logic             clock = 1'b0;
  logic             rstn  = 1'b1;
  logic             enabled_in = 1'b0;
  logic             credit_return_in = 1'b0;
  CommandBufferLine cmd_in [4];
  BufferStatus      read_bs, pr_bs, pw_bs, wr_bs;
  CommandBufferLine command_out;
  logic [7:0]       credit_count_out;
  logic [3:0]       overflow_out;
`ifdef CMD_ARB_STATS_EN
  logic [0:127]     stats_out;
`endif

  always #5 clock = ~clock;

  cu_command_arbiter #(
    .FIFO_DEPTH(DEPTH), .CREDITS_INIT(CINIT), .CREDITS_MAX(CMAX)
  ) dut (
    .clock                        (clock),
    .rstn                         (rstn),
    .enabled_in                   (enabled_in),
    .read_command_in              (cmd_in[0]),
    .prefetch_read_command_in     (cmd_in[1]),
    .prefetch_write_command_in    (cmd_in[2]),
    .write_command_in             (cmd_in[3]),
    .credit_return_in             (credit_return_in),
    .read_buffer_status           (read_bs),
    .prefetch_read_buffer_status  (pr_bs),
    .prefetch_write_buffer_status (pw_bs),
    .write_buffer_status          (wr_bs),
    .command_out                  (command_out),
    .credit_count_out             (credit_count_out),
    .overflow_out                 (overflow_out)
`ifdef CMD_ARB_STATS_EN
    ,
    .cmd_arb_stats_out            (stats_out)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  CommandBufferLine mq [4][$];
  CommandBufferLine exp_q [$];
  CommandBufferLine m_last;
  int               m_credit;
  int               m_rr;
  logic [3:0]       m_ovf;
  logic             m_valid;
  int unsigned      m_stat [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic CommandBufferLine rand_cmd();
    CommandBufferLine r;
    r.valid   = 1'b1;
    r.command = 8'($urandom);
    r.tag     = 8'($urandom);
    r.address = {$urandom, $urandom};
    r.size    = 12'($urandom);
    return r;
  endfunction

  task automatic set_push(input logic [3:0] mask);
    for (int c = 0; c < 4; c++) cmd_in[c] = mask[c] ? rand_cmd() : '0;
  endtask

  function automatic BufferStatus dut_status(input int c);
    case (c)
      0: return read_bs;
      1: return pr_bs;
      2: return pw_bs;
      default: return wr_bs;
    endcase
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      mq[c].delete();
      m_stat[c] = 0;
    end
    exp_q.delete();
    m_last   = '0;
    m_credit = CINIT;
    m_rr     = 0;
    m_ovf    = 4'b0000;
    m_valid  = 1'b0;
  endfunction

  // Predict what the next clock edge does with the inputs currently driven.
  function automatic void model_step();
    int g;
    CommandBufferLine e;
    g = -1;
    if (enabled_in && m_credit > 0) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_rr + k) % 4;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
    end
    m_valid = (g >= 0);
    if (g >= 0) begin
      e = mq[g].pop_front();
      e.valid = 1'b1;
      exp_q.push_back(e);
      m_last = e;
      m_rr = (g + 1) % 4;
      m_stat[g]++;
    end
    for (int c = 0; c < 4; c++) begin
      if (cmd_in[c].valid) begin
        if (mq[c].size() < DEPTH) mq[c].push_back(cmd_in[c]);
        else m_ovf[c] = 1'b1;
      end
    end
    if (g >= 0 && !credit_return_in) m_credit--;
    else if (g < 0 && credit_return_in && m_credit < CMAX) m_credit++;
  endfunction

  task automatic check_outputs();
    CommandBufferLine a, b;
    BufferStatus es;
    check("cmd_valid", 128'(command_out.valid), 128'(m_valid));
    check("credit_count", 128'(credit_count_out), 128'(m_credit));
    check("overflow", 128'(overflow_out), 128'(m_ovf));
    for (int c = 0; c < 4; c++) begin
      es.empty  = (mq[c].size() == 0);
      es.alfull = (mq[c].size() >= DEPTH - 2);
      es.full   = (mq[c].size() == DEPTH);
      check($sformatf("status_ch%0d", c), 128'(dut_status(c)), 128'(es));
    end
    if (!m_valid) begin
      a = command_out; a.valid = 1'b0;
      b = m_last;      b.valid = 1'b0;
      check("payload_hold", 128'(a), 128'(b));
    end
`ifdef CMD_ARB_STATS_EN
    check("stats", 128'(stats_out), {m_stat[0], m_stat[1], m_stat[2], m_stat[3]});
`endif
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic apply_reset();
    set_push(4'b0000);
    credit_return_in = 1'b0;
    enabled_in = 1'b0;
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge clock);
    #1 rstn = 1'b1;
  endtask

  // Scoreboard monitor: every presented command must match the oldest predicted one.
  always @(negedge clock) begin
    if (rstn && command_out.valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_cmd: got %0h expected none", command_out);
      end else begin
        CommandBufferLine e;
        e = exp_q.pop_front();
        check("sb_cmd", 128'(command_out), 128'(e));
      end
    end
  end

  initial begin
    CommandBufferLine saved [4];
    CommandBufferLine want;
    int n;
    for (int c = 0; c < 4; c++) cmd_in[c] = '0;
    #2;

    // 1: single read command, two-edge latency, one credit consumed
    apply_reset();
    enabled_in = 1'b1;
    set_push(4'b0001);
    step();
    check("t1_valid_after_write", 128'(command_out.valid), 128'(1'b0));
    set_push(4'b0000);
    step();
    check("t1_valid_after_reg", 128'(command_out.valid), 128'(1'b1));
    check("t1_credit", 128'(credit_count_out), 128'(8'd63));

    // 2: all channels at once -> ch0..ch3 on consecutive cycles
    apply_reset();
    enabled_in = 1'b1;
    set_push(4'b1111);
    for (int c = 0; c < 4; c++) saved[c] = cmd_in[c];
    step();
    set_push(4'b0000);
    for (int k = 0; k < 4; k++) begin
      step();
      want = saved[k];
      check($sformatf("t2_order_%0d", k), 128'(command_out), 128'(want));
    end

    // 3: nine write pushes while disabled, then drain
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      set_push(4'b1000);
      step();
      case (i)
        4: check("t3_alfull_at5", 128'(wr_bs.alfull), 128'(1'b0));
        5: check("t3_alfull_at6", 128'(wr_bs.alfull), 128'(1'b1));
        6: check("t3_full_at7", 128'(wr_bs.full), 128'(1'b0));
        7: check("t3_full_at8", 128'(wr_bs.full), 128'(1'b1));
        8: check("t3_overflow", 128'(overflow_out), 128'(4'b1000));
        default: ;
      endcase
    end
    set_push(4'b0000);
    enabled_in = 1'b1;
    n = 0;
    repeat (10) begin
      step();
      if (command_out.valid) n++;
    end
    check("t3_drained", 128'(n), 128'(8));
    check("t3_empty", 128'(wr_bs.empty), 128'(1'b1));

    // 4: exhaust credits, then a single return releases exactly one command
    apply_reset();
    enabled_in = 1'b1;
    repeat (70) begin
      set_push(4'b0001);
      step();
    end
    set_push(4'b0000);
    n = 0;
    repeat (5) begin
      step();
      if (command_out.valid) n++;
    end
    check("t4_no_issue", 128'(n), 128'(0));
    check("t4_credit0", 128'(credit_count_out), 128'(8'd0));
    credit_return_in = 1'b1;
    step();
    credit_return_in = 1'b0;
    n = 0;
    repeat (4) begin
      step();
      if (command_out.valid) n++;
    end
    check("t4_one_issue", 128'(n), 128'(1));

    // 5: return with grant at max, then return alone at max
    apply_reset();
    enabled_in = 1'b1;
    set_push(4'b0010);
    step();
    set_push(4'b0000);
    credit_return_in = 1'b1;
    step();
    check("t5_grant_and_return", 128'(credit_count_out), 128'(8'd64));
    step();
    check("t5_return_at_max", 128'(credit_count_out), 128'(8'd64));
    credit_return_in = 1'b0;

    // 6: reset with five entries queued
    enabled_in = 1'b0;
    repeat (5) begin
      set_push(4'b0100);
      step();
    end
    set_push(4'b0000);
    rstn = 1'b0;
    #1;
    check("t6_status", 128'(pw_bs), 128'(3'b100));
    check("t6_valid", 128'(command_out.valid), 128'(1'b0));
    check("t6_credit", 128'(credit_count_out), 128'(8'd64));
`ifdef CMD_ARB_STATS_EN
    check("t6_stats", 128'(stats_out), 128'(0));
`endif
    model_reset();
    repeat (2) @(posedge clock);
    #1 rstn = 1'b1;

    // Randomised traffic with one mid-run reset, then a drain
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [3:0] mask;
      if (cyc == 300) apply_reset();
      for (int c = 0; c < 4; c++) mask[c] = ($urandom_range(0, 99) < 30);
      set_push(mask);
      enabled_in = ($urandom_range(0, 9) != 0);
      credit_return_in = ($urandom_range(0, 99) < 60);
      step();
    end
    set_push(4'b0000);
    enabled_in = 1'b1;
    credit_return_in = 1'b1;
    repeat (40) step();
    credit_return_in = 1'b0;
    step();
    @(negedge clock);
    #1;
    check("sb_drained", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
